cla_add_pipe: RTL and testbench

- Two-stage pipelined carry-lookahead adder built on the existing 4-bit generate/propagate pre-stage and group lookahead logic.
- Stage 1 registers operands with bit and group generate/propagate. Stage 2 resolves group carries, forms sums, and registers the result.
- Valid/ready handshake on both sides, so it can sit between an operand source and a result consumer in the datapath.
- Throughput 1 add/cycle; latency 2 cycles.

---
 rtl/cla_add_pipe.sv | 137 +++++++++++++
 tb/tb_cla_add_pipe.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/cla_add_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// Optional macro CLA_OVF_EN adds the registered signed-overflow output o_ovf.

// Per-group pre-stage: bit generate/propagate, half-sum and group G/P.
module cla_grp_pre (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [3:0] o_g,
  output logic [3:0] o_p,
  output logic [3:0] o_x,
  output logic       o_gg,
  output logic       o_pp
);
  assign o_g  = i_a & i_b;
  assign o_p  = i_a | i_b;
  assign o_x  = i_a ^ i_b;
  assign o_gg = o_g[3] | (o_p[3] & o_g[2]) | (o_p[3] & o_p[2] & o_g[1]) |
                (o_p[3] & o_p[2] & o_p[1] & o_g[0]);
  assign o_pp = &o_p;
endmodule

// Per-group sum: lookahead carries within the group from the group carry-in.
module cla_grp_sum (
  input  logic [3:0] i_g,
  input  logic [3:0] i_p,
  input  logic [3:0] i_x,
  input  logic       i_c,
  output logic [3:0] o_s
);
  logic [3:0] w_c;
  assign w_c[0] = i_c;
  assign w_c[1] = i_g[0] | (i_p[0] & i_c);
  assign w_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_c);
  assign w_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0]) |
                  (i_p[2] & i_p[1] & i_p[0] & i_c);
  assign o_s    = i_x ^ w_c;
endmodule

module cla_add_pipe #(
  parameter  int NGROUPS = 4,
  localparam int W       = 4 * NGROUPS
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_sum,
  output logic         o_cout
`ifdef CLA_OVF_EN
  ,
  output logic         o_ovf
`endif
);

  typedef struct packed {
    logic [W-1:0]       g;
    logic [W-1:0]       p;
    logic [W-1:0]       x;
    logic [NGROUPS-1:0] gg;
    logic [NGROUPS-1:0] pp;
    logic               cin;
  } s1_t;

  s1_t                r_s1;
  logic [2:1]         r_vld_pipe;   // [1] = stage-1 full, [2] = result valid
  logic [W-1:0]       r_sum;
  logic               r_cout;
  logic [W-1:0]       w_g, w_p, w_x, w_sum;
  logic [NGROUPS-1:0] w_gg, w_pp;
  logic [NGROUPS:0]   w_c;
  logic               w_adv2, w_acc;

  assign w_adv2  = r_vld_pipe[1] & (~r_vld_pipe[2] | i_ready);
  assign o_ready = ~r_vld_pipe[1] | w_adv2;
  assign w_acc   = i_valid & o_ready;
  assign w_c[0]  = r_s1.cin;

  for (genvar k = 0; k < NGROUPS; k++) begin : g_grp
    cla_grp_pre u_pre (
      .i_a (i_a[4*k +: 4]),
      .i_b (i_b[4*k +: 4]),
      .o_g (w_g[4*k +: 4]),
      .o_p (w_p[4*k +: 4]),
      .o_x (w_x[4*k +: 4]),
      .o_gg(w_gg[k]),
      .o_pp(w_pp[k])
    );
    assign w_c[k+1] = r_s1.gg[k] | (r_s1.pp[k] & w_c[k]);
    cla_grp_sum u_sum (
      .i_g(r_s1.g[4*k +: 4]),
      .i_p(r_s1.p[4*k +: 4]),
      .i_x(r_s1.x[4*k +: 4]),
      .i_c(w_c[k]),
      .o_s(w_sum[4*k +: 4])
    );
  end

  // Stage-1 payload needs no reset: it is only consumed under r_vld_pipe[1].
  always_ff @(posedge i_clk) begin
    if (w_acc) r_s1 <= '{g: w_g, p: w_p, x: w_x, gg: w_gg, pp: w_pp, cin: i_cin};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vld_pipe <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
    end else begin
      r_vld_pipe[1] <= w_acc | (r_vld_pipe[1] & ~w_adv2);
      r_vld_pipe[2] <= w_adv2 | (r_vld_pipe[2] & ~i_ready);
      if (w_adv2) begin
        r_sum  <= w_sum;
        r_cout <= w_c[NGROUPS];
      end
    end
  end

`ifdef CLA_OVF_EN
  logic r_ovf;
  // Carry into the MSB is recovered as sum ^ half-sum at that bit.
  always_ff @(posedge i_clk) begin
    if (i_rst)       r_ovf <= 1'b0;
    else if (w_adv2) r_ovf <= (w_sum[W-1] ^ r_s1.x[W-1]) ^ w_c[NGROUPS];
  end
  assign o_ovf = r_ovf;
`endif

  assign o_valid = r_vld_pipe[2];
  assign o_sum   = r_sum;
  assign o_cout  = r_cout;

endmodule

// File: tb/tb_cla_add_pipe.sv
// Self-checking bench for cla_add_pipe: reference queue model with plain arithmetic.
module tb_cla_add_pipe;
  localparam int NG = 4;
  localparam int W  = 4 * NG;

  logic         i_clk = 1'b0;
  logic         i_rst, i_valid, i_ready, i_cin;
  logic [W-1:0] i_a, i_b;
  logic         o_ready, o_valid, o_cout;
  logic [W-1:0] o_sum;
`ifdef CLA_OVF_EN
  logic         o_ovf;
`endif

  cla_add_pipe #(.NGROUPS(NG)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .i_cin  (i_cin),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_sum  (o_sum),
    .o_cout (o_cout)
`ifdef CLA_OVF_EN
    ,
    .o_ovf  (o_ovf)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           t;
  } item_t;

  item_t q[$];
  item_t last;
  int    cyc    = 0;
  int    total  = 0;
  int    passed = 0;

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic item_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input int t);
    item_t       it;
    logic [W:0]  full;
    full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    it.sum  = full[W-1:0];
    it.cout = full[W];
    // Signed overflow: like-signed operands producing a result of the other sign.
    it.ovf  = (a[W-1] == b[W-1]) && (it.sum[W-1] != a[W-1]);
    it.t    = t;
    return it;
  endfunction

  task automatic check_out(input string tag);
    if (o_valid === 1'b1) begin
      chk({tag, ".sum"},  {1'b0, o_sum},  {1'b0, q[0].sum});
      chk({tag, ".cout"}, {{W{1'b0}}, o_cout}, {{W{1'b0}}, q[0].cout});
`ifdef CLA_OVF_EN
      chk({tag, ".ovf"},  {{W{1'b0}}, o_ovf},  {{W{1'b0}}, q[0].ovf});
`endif
    end else begin
      chk({tag, ".hold"}, {o_cout, o_sum}, {last.cout, last.sum});
`ifdef CLA_OVF_EN
      chk({tag, ".hovf"}, {{W{1'b0}}, o_ovf}, {{W{1'b0}}, last.ovf});
`endif
    end
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic rdy);
    logic exp_rdy, exp_vld;
    i_valid = v; i_a = a; i_b = b; i_cin = cin; i_ready = rdy;
    #1;
    exp_rdy = (q.size() < 2) || rdy;
    exp_vld = (q.size() > 0) && (cyc - q[0].t >= 1);
    chk("o_ready", {{W{1'b0}}, o_ready}, {{W{1'b0}}, exp_rdy});
    chk("o_valid", {{W{1'b0}}, o_valid}, {{W{1'b0}}, exp_vld});
    if (o_valid === exp_vld) check_out("res");
    if (exp_vld && rdy) last = q.pop_front();
    if (v && exp_rdy) q.push_back(model(a, b, cin, cyc + 1));
    @(posedge i_clk); cyc++;
    @(negedge i_clk);
  endtask

  task automatic reset_cycle();
    i_rst = 1'b1; i_valid = 1'b1; i_ready = 1'b0;
    @(posedge i_clk); cyc++;
    @(negedge i_clk);
    i_rst = 1'b0; i_valid = 1'b0;
    q.delete();
    last = '{sum: '0, cout: 1'b0, ovf: 1'b0, t: 0};
    #1;
    chk("rst.o_valid", {{W{1'b0}}, o_valid}, '0);
    chk("rst.o_sum",   {1'b0, o_sum},        '0);
    chk("rst.o_cout",  {{W{1'b0}}, o_cout},  '0);
    chk("rst.o_ready", {{W{1'b0}}, o_ready}, {{W{1'b0}}, 1'b1});
`ifdef CLA_OVF_EN
    chk("rst.o_ovf",   {{W{1'b0}}, o_ovf},   '0);
`endif
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("drain.empty", q.size(), 0);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] one;
    logic [W-1:0] msb;
    ones = '1; one = 1; msb = {1'b1, {(W-1){1'b0}}};
    i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; i_a = '0; i_b = '0; i_cin = 1'b0;
    last = '{sum: '0, cout: 1'b0, ovf: 1'b0, t: 0};
    @(negedge i_clk);
    reset_cycle();

    // Single op, then latency visible through the valid check.
    step(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
    drain();

    // Full carry chain and wrap-around.
    step(1'b1, ones, '0, 1'b1, 1'b1);
    step(1'b1, ones, one, 1'b0, 1'b1);
    step(1'b1, ones >> 1, one, 1'b0, 1'b1);
    step(1'b1, msb, msb, 1'b0, 1'b1);
    step(1'b1, ones, ones, 1'b1, 1'b1);
    drain();

    // Back-to-back random stream.
    for (int i = 0; i < 8; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);

    // Backpressure for 5 cycles mid-stream.
    for (int i = 0; i < 5; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b1);
    drain();

    // Random valid/ready mix.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom),
           1'($urandom_range(0, 2) != 0));
    drain();

    // Reset with both stages full, then a fresh op.
    step(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0);
    step(1'b1, W'($urandom), W'($urandom), 1'b1, 1'b0);
    chk("full.q", q.size(), 2);
    reset_cycle();
    step(1'b1, 16'h00FF, 16'h0F01, 1'b1, 1'b1);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
